micro_sequencer: RTL and testbench

Microprogrammed controller for the 16-register / dual-mux / 2-op ALU datapath. It runs a small loadable microprogram and produces the 15-bit datapath control word each instruction, in the same bit layout the datapath already decodes. It branches on the ALU "mayor" flag and exposes a start/busy/done handshake, so the datapath can run arbitrary sequences (divide, multiply, compare loops) without a hard-wired control FSM.

---
 rtl/micro_sequencer_pkg.sv | 55 +++++
 rtl/micro_sequencer_prog_mem.sv | 33 +++
 rtl/micro_sequencer.sv | 136 +++++++++++++
 tb/tb_micro_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/micro_sequencer_pkg.sv
// Shared encodings for the micro_sequencer: next-op codes, control-word field
// positions, FSM states and ALU op codes used by the datapath.
package micro_sequencer_pkg;

    // Control-word field positions, matching the datapath decoder.
    localparam int CW_ALU_MSB  = 14;
    localparam int CW_ALU_LSB  = 13;
    localparam int CW_MUXA_MSB = 12;
    localparam int CW_MUXA_LSB = 9;
    localparam int CW_MUXB_MSB = 8;
    localparam int CW_MUXB_LSB = 5;
    localparam int CW_DEST_MSB = 4;
    localparam int CW_DEST_LSB = 1;
    localparam int CW_WE_BIT   = 0;

    typedef enum logic [1:0] {
        NOP_NEXT = 2'b00,
        NOP_JUMP = 2'b01,
        NOP_BR   = 2'b10,
        NOP_HALT = 2'b11
    } nop_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_FETCH = 2'b01,
        S_EXEC  = 2'b10,
        S_DONE  = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        ALU_ADD    = 2'b00,
        ALU_SUB    = 2'b01,
        ALU_PASS_A = 2'b10,
        ALU_PASS_B = 2'b11
    } alu_op_e;

    // Assembles a 15-bit control word from its fields.
    function automatic logic [14:0] make_cw(
        input alu_op_e    alu,
        input logic [3:0] mux_a,
        input logic [3:0] mux_b,
        input logic [3:0] dest,
        input logic       we
    );
        logic [14:0] cw;
        cw = '0;
        cw[CW_ALU_MSB:CW_ALU_LSB]   = alu;
        cw[CW_MUXA_MSB:CW_MUXA_LSB] = mux_a;
        cw[CW_MUXB_MSB:CW_MUXB_LSB] = mux_b;
        cw[CW_DEST_MSB:CW_DEST_LSB] = dest;
        cw[CW_WE_BIT]               = we;
        return cw;
    endfunction

endpackage

// File: rtl/micro_sequencer_prog_mem.sv
// Microprogram store: 2^ADDR_W x IW RAM with one write port and a registered,
// enable-gated read port. Contents survive reset.
module seq_prog_mem #(
    parameter int ADDR_W = 5,
    parameter int IW     = 22
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [IW-1:0]     wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [IW-1:0]     rdata_o
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [IW-1:0] mem [DEPTH];
    logic [IW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        // Read is held when not enabled so the fetched word stays stable in EXEC.
        if (re_i) begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/micro_sequencer.sv
// Microprogrammed controller emitting the datapath control word, two cycles per
// instruction. Optional macro SINGLE_STEP_EN adds a 'step' input gating FETCH.
module micro_sequencer
    import micro_sequencer_pkg::*;
#(
    parameter  int ADDR_W = 5,
    parameter  int CW_W   = 15,
    parameter  int CNT_W  = 16,
    localparam int IW     = CW_W + 2 + ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mayor,
`ifdef SINGLE_STEP_EN
    input  logic              step,
`endif
    output logic [CW_W-1:0]   o_signal,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] pc,
    output logic [CNT_W-1:0]  inst_count,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [IW-1:0]     prog_data
);

    state_e             state_q;
    logic [ADDR_W-1:0]  pc_q;
    logic [ADDR_W-1:0]  pc_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic               done_q;
    logic               exec_q;
    logic [IW-1:0]      inst_rdata;
    logic [CW_W-1:0]    inst_cw;
    nop_e               inst_nop;
    logic [ADDR_W-1:0]  inst_target;
    logic               mem_we;
    logic               mem_re;
    logic               step_ok;

`ifdef SINGLE_STEP_EN
    assign step_ok = step;
`else
    assign step_ok = 1'b1;
`endif

    assign mem_we = prog_we && (state_q == S_IDLE);
    assign mem_re = (state_q == S_FETCH);

    seq_prog_mem #(
        .ADDR_W (ADDR_W),
        .IW     (IW)
    ) u_prog_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (prog_addr),
        .wdata_i (prog_data),
        .re_i    (mem_re),
        .raddr_i (pc_q),
        .rdata_o (inst_rdata)
    );

    assign inst_cw     = inst_rdata[CW_W-1:0];
    assign inst_nop    = nop_e'(inst_rdata[CW_W+1:CW_W]);
    assign inst_target = inst_rdata[IW-1:CW_W+2];

    always_comb begin
        pc_d = pc_q + 1'b1;
        unique case (inst_nop)
            NOP_NEXT: pc_d = pc_q + 1'b1;
            NOP_JUMP: pc_d = inst_target;
            NOP_BR:   pc_d = mayor ? inst_target : pc_q + 1'b1;
            NOP_HALT: pc_d = pc_q;
            default:  pc_d = pc_q + 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            exec_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            exec_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        pc_q    <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (step_ok) begin
                        exec_q  <= 1'b1;
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (cnt_q != '1) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                    pc_q <= pc_d;
                    if (inst_nop == NOP_HALT) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        state_q <= S_FETCH;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Gated by rst as well so an abort never lets a register-file write through.
    assign o_signal   = (exec_q && !rst) ? inst_cw : '0;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pc         = pc_q;
    assign inst_count = cnt_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed self-checking bench for micro_sequencer (step tests only when
// SINGLE_STEP_EN is defined).
module tb_micro_sequencer;

    localparam logic [1:0] NXT = 2'b00;
    localparam logic [1:0] JMP = 2'b01;
    localparam logic [1:0] BRM = 2'b10;
    localparam logic [1:0] HLT = 2'b11;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        mayor;
`ifdef SINGLE_STEP_EN
    logic        step;
`endif
    logic [14:0] o_signal;
    logic        busy;
    logic        done;
    logic [4:0]  pc;
    logic [15:0] inst_count;
    logic        prog_we;
    logic [4:0]  prog_addr;
    logic [21:0] prog_data;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    micro_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mayor      (mayor),
`ifdef SINGLE_STEP_EN
        .step       (step),
`endif
        .o_signal   (o_signal),
        .busy       (busy),
        .done       (done),
        .pc         (pc),
        .inst_count (inst_count),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("check %-18s got 0x%0h exp 0x%0h ok", tag, got, exp);
        end else begin
            $display("FAIL %-18s got 0x%0h exp 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [21:0] mk(input int tgt, input logic [1:0] nop, input logic [14:0] cw);
        logic [4:0] t;
        t = tgt[4:0];
        return {t, nop, cw};
    endfunction

    task automatic prog(input int a, input logic [21:0] d);
        prog_we   = 1'b1;
        prog_addr = a[4:0];
        prog_data = d;
        @(negedge clk);
        prog_we   = 1'b0;
    endtask

    // Returns at cycle 1 (FETCH of address 0).
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, input string tag);
        int n;
        n = 0;
        while (done !== 1'b1 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'b0, done}, 32'd1);
    endtask

    initial begin
        int  prev_pc;
        bit  wrapped;
        rst = 1'b1; start = 1'b0; mayor = 1'b0;
        prog_we = 1'b0; prog_addr = '0; prog_data = '0;
`ifdef SINGLE_STEP_EN
        step = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst_osig", {17'b0, o_signal}, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_done", {31'b0, done}, 32'h0);
        check("rst_pc",   {27'b0, pc}, 32'h0);
        check("rst_cnt",  {16'b0, inst_count}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Two-instruction program: exact cycle timing of EXEC and done.
        prog(0, mk(0, NXT, 15'h0003));
        prog(1, mk(0, HLT, 15'h0000));
        pulse_start();
        check("t1_c1_busy", {31'b0, busy}, 32'h1);
        check("t1_c1_osig", {17'b0, o_signal}, 32'h0);
        @(negedge clk);
        check("t1_c2_osig", {17'b0, o_signal}, 32'h0003);
        @(negedge clk);
        check("t1_c3_osig", {17'b0, o_signal}, 32'h0);
        check("t1_c3_pc",   {27'b0, pc}, 32'h1);
        @(negedge clk);
        check("t1_c4_done", {31'b0, done}, 32'h0);
        @(negedge clk);
        check("t1_c5_done", {31'b0, done}, 32'h1);
        check("t1_c5_busy", {31'b0, busy}, 32'h0);
        check("t1_c5_cnt",  {16'b0, inst_count}, 32'd2);
        @(negedge clk);
        check("t1_c6_done", {31'b0, done}, 32'h0);

        // Conditional branch, taken and not taken.
        prog(0, mk(5, BRM, 15'h1235));
        prog(5, mk(0, HLT, 15'h0000));
        for (int k = 0; k < 2; k++) begin
            mayor = (k == 0);
            pulse_start();
            @(negedge clk);
            check("t2_br_osig", {17'b0, o_signal}, 32'h1235);
            @(negedge clk);
            check(k == 0 ? "t2_br_taken" : "t2_br_not", {27'b0, pc}, (k == 0) ? 32'd5 : 32'd1);
            wait_done(10, "t2_done");
            @(negedge clk);
        end

        // Wrap: branch over HALT at 1 first, fall into it after 31 -> 0.
        prog(0, mk(2, BRM, 15'h0040));
        prog(1, mk(0, HLT, 15'h0000));
        for (int a = 2; a < 32; a++) prog(a, mk(0, NXT, 15'(a)));
        mayor   = 1'b1;
        wrapped = 1'b0;
        pulse_start();
        prev_pc = 0;
        for (int c = 0; c < 200 && done !== 1'b1; c++) begin
            @(negedge clk);
            if (pc != 5'd0) mayor = 1'b0;
            if (prev_pc == 31 && pc == 5'd0) wrapped = 1'b1;
            prev_pc = int'(pc);
        end
        check("t3_done",  {31'b0, done}, 32'h1);
        check("t3_wrap",  {31'b0, wrapped}, 32'h1);
        check("t3_cnt",   {16'b0, inst_count}, 32'd33);
        check("t3_pc",    {27'b0, pc}, 32'd1);
        @(negedge clk);

        // Reset during EXEC of a write-enabled instruction.
        prog(0, mk(0, NXT, 15'h4A2B));
        prog(1, mk(0, HLT, 15'h0000));
        pulse_start();
        @(negedge clk);
        check("t4_exec_osig", {17'b0, o_signal}, 32'h4A2B);
        rst = 1'b1;
        @(negedge clk);
        check("t4_osig", {17'b0, o_signal}, 32'h0);
        check("t4_busy", {31'b0, busy}, 32'h0);
        check("t4_pc",   {27'b0, pc}, 32'h0);
        check("t4_cnt",  {16'b0, inst_count}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // start / prog_we while busy and start during DONE are ignored.
        prog(0, mk(0, NXT, 15'h0011));
        prog(1, mk(3, JMP, 15'h0021));
        prog(3, mk(0, HLT, 15'h0000));
        pulse_start();
        @(negedge clk);
        start = 1'b1; prog_we = 1'b1; prog_addr = 5'd0; prog_data = mk(0, HLT, 15'h7777);
        check("t5_osig0", {17'b0, o_signal}, 32'h0011);
        @(negedge clk);
        start = 1'b0; prog_we = 1'b0;
        check("t5_pc_jump", {27'b0, pc}, 32'd1);
        wait_done(20, "t5_done");
        check("t5_cnt", {16'b0, inst_count}, 32'd3);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("t5_ign_busy", {31'b0, busy}, 32'h0);
        pulse_start();
        @(negedge clk);
        check("t5_mem_kept", {17'b0, o_signal}, 32'h0011);
        wait_done(20, "t5_done2");
        check("t5_cnt2", {16'b0, inst_count}, 32'd3);
        @(negedge clk);

`ifdef SINGLE_STEP_EN
        begin
            logic [14:0] exp_cw [3];
            bit          quiet;
            exp_cw[0] = 15'h0101; exp_cw[1] = 15'h0202; exp_cw[2] = 15'h0303;
            prog(0, mk(0, NXT, exp_cw[0]));
            prog(1, mk(0, NXT, exp_cw[1]));
            prog(2, mk(0, HLT, exp_cw[2]));
            pulse_start();
            for (int i = 0; i < 3; i++) begin
                quiet = 1'b1;
                for (int w = 0; w < 9; w++) begin
                    @(negedge clk);
                    if (o_signal != 15'h0) quiet = 1'b0;
                end
                check("ss_quiet", {31'b0, quiet}, 32'h1);
                step = 1'b1;
                @(negedge clk);
                step = 1'b0;
                check("ss_exec", {17'b0, o_signal}, {17'b0, exp_cw[i]});
            end
            wait_done(10, "ss_done");
            check("ss_cnt", {16'b0, inst_count}, 32'd3);
            @(negedge clk);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
